ir_nec_rx: RTL and testbench

Parametrised NEC-protocol infrared receiver. It is the successor to the fixed four-key IR decoder. It samples the demodulated IR receiver output and times pulses on a programmable tick. It decodes the full 32-bit frame LSB-first, checks the inverted address and command bytes, recognises repeat codes, and drives up to NUM_KEYS active-low key strobes of configurable length. It sits between the IR receiver pin and the control FSMs that consume the cdleft/cdright-style key lines.

---
 rtl/ir_nec_rx_if.sv | 28 ++
 rtl/ir_nec_rx.sv | 234 +++++++++++++++++++++++
 tb/tb_ir_nec_rx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ir_nec_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : ir_nec_rx_if
// Brief    : IR line input and decoded frame/key outputs of ir_nec_rx.
// Revision : 1.0
// ============================================================================
interface ir_nec_rx_if #(
    parameter int NUM_KEYS = 4
);
    logic                ir_in;
    logic                frame_valid;
    logic                repeat_valid;
    logic                frame_err;
    logic [15:0]         addr;
    logic [7:0]          cmd;
    logic [NUM_KEYS-1:0] key_n;

    modport master (
        output ir_in,
        input  frame_valid, repeat_valid, frame_err, addr, cmd, key_n
    );

    modport slave (
        input  ir_in,
        output frame_valid, repeat_valid, frame_err, addr, cmd, key_n
    );
endinterface
`default_nettype wire

// File: rtl/ir_nec_rx.sv
`default_nettype none
// ============================================================================
// Module   : ir_nec_rx
// Brief    : NEC infrared frame/repeat decoder with programmable key strobes.
// Revision : 1.0
// ============================================================================
module ir_nec_rx #(
    parameter int                  TICK_DIV       = 500,
    parameter int                  CNT_W          = 11,
    parameter int                  LEAD_LOW_MIN   = 800,
    parameter int                  LEAD_HIGH_MIN  = 400,
    parameter int                  REP_HIGH_MIN   = 180,
    parameter int                  BIT_LOW_MIN    = 40,
    parameter int                  BIT_LOW_MAX    = 75,
    parameter int                  ZERO_MAX       = 90,
    parameter int                  ONE_MAX        = 200,
    parameter int                  TIMEOUT        = 1200,
    parameter int                  CHECK_ADDR     = 1,
    parameter logic [7:0]          DEV_ADDR       = 8'h00,
    parameter int                  NUM_KEYS       = 4,
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES    = 32'h1217_1814,
    parameter int                  KEY_HOLD       = 1,
    parameter int                  REPEAT_EN      = 1
) (
    input  logic        clk,
    input  logic        rst,
    ir_nec_rx_if.slave  bus
);

    localparam int c_div_w  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_hold_w = (KEY_HOLD > 1) ? $clog2(KEY_HOLD) : 1;

    localparam logic [c_div_w-1:0]  c_div_last      = c_div_w'(TICK_DIV - 1);
    localparam logic [c_hold_w-1:0] c_hold_init     = c_hold_w'(KEY_HOLD - 1);
    localparam logic [CNT_W-1:0]    c_cnt_max       = '1;
    localparam logic [CNT_W-1:0]    c_lead_low_min  = CNT_W'(LEAD_LOW_MIN);
    localparam logic [CNT_W-1:0]    c_lead_high_min = CNT_W'(LEAD_HIGH_MIN);
    localparam logic [CNT_W-1:0]    c_rep_high_min  = CNT_W'(REP_HIGH_MIN);
    localparam logic [CNT_W-1:0]    c_bit_low_min   = CNT_W'(BIT_LOW_MIN);
    localparam logic [CNT_W-1:0]    c_bit_low_max   = CNT_W'(BIT_LOW_MAX);
    localparam logic [CNT_W-1:0]    c_zero_max      = CNT_W'(ZERO_MAX);
    localparam logic [CNT_W-1:0]    c_one_max       = CNT_W'(ONE_MAX);
    localparam logic [CNT_W-1:0]    c_timeout       = CNT_W'(TIMEOUT);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LEAD_LOW  = 3'd1;
    localparam logic [2:0] S_LEAD_HIGH = 3'd2;
    localparam logic [2:0] S_BIT_LOW   = 3'd3;
    localparam logic [2:0] S_BIT_HIGH  = 3'd4;
    localparam logic [2:0] S_CHECK     = 3'd5;

    logic [1:0]          r_sync;
    logic                r_ir_d;
    logic                r_fall;
    logic                r_rise;
    logic [c_div_w-1:0]  r_div;
    logic                w_tick;
    logic [2:0]          r_state;
    logic [2:0]          w_state_nx;
    logic [CNT_W-1:0]    r_cnt;
    logic [31:0]         r_shift;
    logic [4:0]          r_bidx;
    logic                r_last_ok;
    logic                r_frame_valid;
    logic                r_repeat_valid;
    logic                r_frame_err;
    logic [15:0]         r_addr;
    logic [7:0]          r_cmd;
    logic [NUM_KEYS-1:0] r_key_n;
    logic [c_hold_w-1:0] r_hold [NUM_KEYS];
    logic [NUM_KEYS-1:0] w_fire;
    logic                w_trig;
    logic                w_fv;
    logic                w_rv;
    logic                w_fe;
    logic                w_bit_we;
    logic                w_bit_val;
    logic                w_check_ok;

    // Synchroniser resets to the idle-high level so release never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_ir_d <= 1'b1;
            r_fall <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], bus.ir_in};
            r_ir_d <= r_sync[1];
            r_fall <= r_ir_d & ~r_sync[1];
            r_rise <= ~r_ir_d & r_sync[1];
        end
    end

    assign w_tick = (r_div == c_div_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_div   <= w_tick ? '0 : r_div + 1'b1;
            r_state <= w_state_nx;
            if (w_state_nx != r_state)
                r_cnt <= '0;
            else if (w_tick && r_cnt != c_cnt_max)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_check_ok = (r_shift[31:24] == ~r_shift[23:16]) &&
                        ((CHECK_ADDR == 0) || (r_shift[15:8] == ~r_shift[7:0]));

    always_comb begin
        w_state_nx = r_state;
        w_fv       = 1'b0;
        w_rv       = 1'b0;
        w_fe       = 1'b0;
        w_bit_we   = 1'b0;
        w_bit_val  = (r_cnt > c_zero_max);
        if (r_state != S_IDLE && r_state != S_CHECK && r_cnt >= c_timeout) begin
            w_state_nx = S_IDLE;
            w_fe       = (r_state == S_BIT_LOW) || (r_state == S_BIT_HIGH);
        end else begin
            case (r_state)
                S_IDLE: if (r_fall) w_state_nx = S_LEAD_LOW;
                S_LEAD_LOW: if (r_rise)
                    w_state_nx = (r_cnt >= c_lead_low_min) ? S_LEAD_HIGH : S_IDLE;
                S_LEAD_HIGH: if (r_fall) begin
                    if (r_cnt >= c_lead_high_min) begin
                        w_state_nx = S_BIT_LOW;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_rv       = r_last_ok && (r_cnt >= c_rep_high_min);
                    end
                end
                S_BIT_LOW: if (r_rise) begin
                    if (r_cnt >= c_bit_low_min && r_cnt <= c_bit_low_max) begin
                        w_state_nx = S_BIT_HIGH;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_fe       = 1'b1;
                    end
                end
                // An over-long high is rejected as soon as it exceeds the 1 window.
                S_BIT_HIGH: begin
                    if (r_cnt > c_one_max || (r_fall && r_cnt < c_bit_low_min)) begin
                        w_state_nx = S_IDLE;
                        w_fe       = 1'b1;
                    end else if (r_fall) begin
                        w_bit_we   = 1'b1;
                        w_state_nx = (r_bidx == 5'd31) ? S_CHECK : S_BIT_LOW;
                    end
                end
                S_CHECK: begin
                    w_state_nx = S_IDLE;
                    w_fv       = w_check_ok;
                    w_fe       = ~w_check_ok;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift        <= '0;
            r_bidx         <= '0;
            r_last_ok      <= 1'b0;
            r_frame_valid  <= 1'b0;
            r_repeat_valid <= 1'b0;
            r_frame_err    <= 1'b0;
            r_addr         <= '0;
            r_cmd          <= '0;
        end else begin
            if (r_state == S_LEAD_HIGH && w_state_nx == S_BIT_LOW) begin
                r_bidx <= '0;
            end else if (w_bit_we) begin
                r_shift[r_bidx] <= w_bit_val;
                r_bidx          <= r_bidx + 1'b1;
            end
            r_frame_valid  <= w_fv;
            r_repeat_valid <= w_rv;
            r_frame_err    <= w_fe;
            if (w_fv) begin
                r_addr    <= (CHECK_ADDR != 0) ? {8'h00, r_shift[7:0]} : r_shift[15:0];
                r_cmd     <= r_shift[23:16];
                r_last_ok <= 1'b1;
            end else if (w_fe) begin
                r_last_ok <= 1'b0;
            end
        end
    end

    // Keys fire from the registered pulse so addr/cmd already hold the new frame.
    assign w_trig = r_frame_valid || ((REPEAT_EN != 0) && r_repeat_valid);

    always_comb begin
        w_fire = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            w_fire[i] = w_trig && (r_addr[7:0] == DEV_ADDR) &&
                        (r_cmd == KEY_CODES[8*i +: 8]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_n <= '1;
            for (int i = 0; i < NUM_KEYS; i++)
                r_hold[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (w_fire[i]) begin
                    r_key_n[i] <= 1'b0;
                    r_hold[i]  <= c_hold_init;
                end else if (r_hold[i] != '0) begin
                    r_key_n[i] <= 1'b0;
                    r_hold[i]  <= r_hold[i] - 1'b1;
                end else begin
                    r_key_n[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.frame_valid  = r_frame_valid;
    assign bus.repeat_valid = r_repeat_valid;
    assign bus.frame_err    = r_frame_err;
    assign bus.addr         = r_addr;
    assign bus.cmd          = r_cmd;
    assign bus.key_n        = r_key_n;

endmodule
`default_nettype wire

// File: tb/tb_ir_nec_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_nec_rx
// Brief    : Directed frame/repeat/noise/reset vectors for ir_nec_rx, TICK_DIV=2.
// Revision : 1.0
// ============================================================================
module tb_ir_nec_rx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ir_nec_rx_if #(.NUM_KEYS(4)) bus ();

    ir_nec_rx #(.TICK_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit         is_rep;
        logic [7:0] a, ai, c, ci;
        bit         fv, rv, fe;
        logic [15:0] addr;
        logic [7:0] cmd;
        logic [3:0] key;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int n_fv = 0, n_rv = 0, n_fe = 0, n_kl = 0, n_ktime = 0;
    bit prev_trig = 1'b0;

    // Pulse and key-low counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            n_fv += int'(bus.frame_valid);
            n_rv += int'(bus.repeat_valid);
            n_fe += int'(bus.frame_err);
            if (bus.key_n != 4'hF) begin
                n_kl++;
                if (!prev_trig) n_ktime++;
            end
            prev_trig = bus.frame_valid | bus.repeat_valid;
        end else begin
            prev_trig = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int ticks);
        bus.ir_in = v;
        repeat (2 * ticks) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        drive(1'b0, 56);
        drive(1'b1, b ? 169 : 56);
    endtask

    task automatic run_vec(input vec_t v);
        int f0, r0, e0, k0, lat;
        logic [31:0] data;
        f0 = n_fv; r0 = n_rv; e0 = n_fe; k0 = n_kl;
        if (v.is_rep) begin
            drive(1'b0, 900);
            drive(1'b1, 225);
            lat = 4;
        end else begin
            data = {v.ci, v.c, v.ai, v.a};
            drive(1'b0, 900);
            drive(1'b1, 450);
            for (int i = 0; i < 32; i++) send_bit(data[i]);
            lat = 5;
        end
        bus.ir_in = 1'b0;
        repeat (lat - 1) @(posedge clk);
        #1;
        chk("early pulse", {29'd0, bus.frame_valid, bus.repeat_valid, bus.frame_err}, 32'd0);
        @(posedge clk); #1;
        chk("frame_valid", bus.frame_valid, v.fv);
        chk("repeat_valid", bus.repeat_valid, v.rv);
        chk("frame_err", bus.frame_err, v.fe);
        chk("addr", bus.addr, v.addr);
        chk("cmd", bus.cmd, v.cmd);
        @(posedge clk); #1;
        chk("key_n strobe", bus.key_n, v.key);
        @(posedge clk); #1;
        chk("key_n release", bus.key_n, 4'hF);
        @(negedge clk);
        drive(1'b0, 50);
        drive(1'b1, 40);
        chk("fv count", n_fv - f0, v.fv);
        chk("rv count", n_rv - r0, v.rv);
        chk("fe count", n_fe - e0, v.fe);
        chk("key low cycles", n_kl - k0, (v.key != 4'hF) ? 1 : 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        vec_t vecs [5];
        vec_t v;
        int   base;
        logic [31:0] data;

        vecs[0] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 4'hF};
        vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'h18, 8'hE7, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h18, 4'hD};
        vecs[2] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h18, 4'hD};
        vecs[3] = '{1'b0, 8'h00, 8'hFF, 8'h18, 8'hE8, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h18, 4'hF};
        vecs[4] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h18, 4'hF};

        rst = 1'b1;
        bus.ir_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset frame_valid", bus.frame_valid, 32'd0);
        chk("reset repeat_valid", bus.repeat_valid, 32'd0);
        chk("reset frame_err", bus.frame_err, 32'd0);
        chk("reset addr", bus.addr, 32'd0);
        chk("reset cmd", bus.cmd, 32'd0);
        chk("reset key_n", bus.key_n, 32'hF);
        rst = 1'b0;
        drive(1'b1, 20);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Short glitch, then a line stuck low past the timeout.
        base = n_fv + n_rv + n_fe + n_kl;
        drive(1'b0, 100);
        drive(1'b1, 100);
        chk("noise pulses", n_fv + n_rv + n_fe + n_kl - base, 32'd0);
        drive(1'b0, 1300);
        drive(1'b1, 100);
        chk("timeout pulses", n_fv + n_rv + n_fe + n_kl - base, 32'd0);

        // Bit 5 high stretched to 300 ticks.
        data = 32'hED12_FE01;
        base = n_fe;
        drive(1'b0, 900);
        drive(1'b1, 450);
        for (int i = 0; i < 5; i++) send_bit(data[i]);
        drive(1'b0, 56);
        drive(1'b1, 190);
        chk("bad bit premature err", n_fe - base, 32'd0);
        drive(1'b1, 110);
        chk("bad bit err", n_fe - base, 32'd1);
        v = '{1'b0, 8'h01, 8'hFE, 8'h12, 8'hED, 1'b1, 1'b0, 1'b0, 16'h0001, 8'h12, 4'hF};
        run_vec(v);

        // Asynchronous reset in the middle of bit 12.
        data = 32'hED12_FF00;
        drive(1'b0, 900);
        drive(1'b1, 450);
        for (int i = 0; i < 12; i++) send_bit(data[i]);
        drive(1'b0, 20);
        #3 rst = 1'b1;
        #1;
        chk("async rst addr", bus.addr, 32'd0);
        chk("async rst cmd", bus.cmd, 32'd0);
        chk("async rst key_n", bus.key_n, 32'hF);
        chk("async rst frame_valid", bus.frame_valid, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        base = n_fv + n_rv + n_fe + n_kl;
        drive(1'b0, 30);
        drive(1'b1, data[12] ? 169 : 56);
        for (int i = 13; i < 24; i++) send_bit(data[i]);
        drive(1'b0, 56);
        drive(1'b1, 100);
        chk("post-reset leftover pulses", n_fv + n_rv + n_fe + n_kl - base, 32'd0);
        v = '{1'b0, 8'h00, 8'hFF, 8'h12, 8'hED, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h12, 4'h7};
        run_vec(v);

        chk("key strobe without trigger", n_ktime, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
